// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - scan sequencer driving a 3:8 line decoder with dwell/blank timing
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               continuous,
  output logic [2:0]         sel,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

  state_t             state;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic [DWELL_W-1:0] cnt;

  logic [2:0]         low_in;
  logic [2:0]         low_q;
  logic [2:0]         next_idx;
  logic               has_next;
  logic [DWELL_W-1:0] reload_in;
  logic [DWELL_W-1:0] reload_q;

  // Priority scans: lowest set line of the live and latched masks, and the next latched line above sel.
  always_comb begin
    low_in   = '0;
    low_q    = '0;
    next_idx = '0;
    has_next = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i])
        low_in = 3'(i);
      if (mask_q[i])
        low_q = 3'(i);
      if (mask_q[i] && (3'(i) > sel)) begin
        has_next = 1'b1;
        next_idx = 3'(i);
      end
    end
  end

  // The counter holds remaining cycles after the current one, so dwell 0 and 1 both give one cycle.
  assign reload_in = (dwell == '0)   ? '0 : dwell - DWELL_W'(1);
  assign reload_q  = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            cont_q  <= continuous;
            if (mask != '0) begin
              state  <= ACTIVE;
              sel    <= low_in;
              enable <= 1'b1;
              busy   <= 1'b1;
              cnt    <= reload_in;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (stop) begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (cnt == '0) begin
            if (has_next) begin
              state  <= BLANK;
              sel    <= next_idx;
              enable <= 1'b0;
            end else if (cont_q) begin
              state  <= BLANK;
              sel    <= low_q;
              enable <= 1'b0;
              wrap   <= 1'b1;
            end else begin
              state  <= IDLE;
              enable <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        BLANK: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= ACTIVE;
            enable <= 1'b1;
            cnt    <= reload_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - table-driven bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, continuous;
  logic [7:0] mask, dwell;
  logic [2:0] sel;
  logic       enable, busy, done, wrap;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask), .dwell(dwell),
    .continuous(continuous), .sel(sel), .enable(enable), .busy(busy), .done(done), .wrap(wrap)
  );

  typedef struct {
    logic       st, sp, r;
    logic [7:0] m, dw;
    logic       c;
    logic [2:0] es;
    logic       ee, eb, ed, ew;
  } vec_t;

  vec_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic row(input logic st, sp, r, input logic [7:0] m, dw, input logic c,
                     input logic [2:0] es, input logic ee, eb, ed, ew);
    vec_t v;
    v.st = st; v.sp = sp; v.r = r; v.m = m; v.dw = dw; v.c = c;
    v.es = es; v.ee = ee; v.eb = eb; v.ed = ed; v.ew = ew;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", idx, name, got, exp);
    end
  endtask

  logic [7:0] acc_mask;
  logic       prev_busy_exp, prev_en;
  logic [2:0] prev_sel;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; mask = '0; dwell = '0;

    // reset state
    row(0,0,1, 8'h00,0,0, 0,0,0,0,0);
    row(0,0,1, 8'h00,0,0, 0,0,0,0,0);

    // mask A4, dwell 3, one pass; restart and input changes mid-scan are ignored
    row(1,0,0, 8'hA4,3,0, 2,1,1,0,0);
    row(1,0,0, 8'h13,7,1, 2,1,1,0,0);
    row(0,0,0, 8'h13,7,1, 2,1,1,0,0);
    row(1,0,0, 8'h01,1,0, 5,0,1,0,0);
    for (int k = 0; k < 3; k++) row(0,0,0, 8'hA4,3,0, 5,1,1,0,0);
    row(0,0,0, 8'hA4,3,0, 7,0,1,0,0);
    for (int k = 0; k < 3; k++) row(0,0,0, 8'hA4,3,0, 7,1,1,0,0);
    row(0,0,0, 8'hA4,3,0, 7,0,0,1,0);
    row(0,0,0, 8'hA4,3,0, 7,0,0,0,0);

    // all lines, dwell 0 behaves as 1
    row(1,0,0, 8'hFF,0,0, 0,1,1,0,0);
    for (int k = 1; k < 8; k++) begin
      row(0,0,0, 8'hFF,0,0, 3'(k),0,1,0,0);
      row(0,0,0, 8'hFF,0,0, 3'(k),1,1,0,0);
    end
    row(0,0,0, 8'hFF,0,0, 7,0,0,1,0);
    row(0,0,0, 8'hFF,0,0, 7,0,0,0,0);

    // continuous 0/7 with wrap, then stop mid-ACTIVE
    row(1,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,0,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 0,0,1,0,1);
    row(0,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,0,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,1,1,0,0);
    row(0,1,0, 8'h81,2,1, 7,0,0,1,0);
    row(0,0,0, 8'h81,2,1, 7,0,0,0,0);

    // stop coinciding with expiry on the top line: done, no wrap
    row(1,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 0,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,0,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,1,1,0,0);
    row(0,0,0, 8'h81,2,1, 7,1,1,0,0);
    row(0,1,0, 8'h81,2,1, 7,0,0,1,0);
    row(0,0,0, 8'h81,2,1, 7,0,0,0,0);

    // single line continuous, stop in BLANK, stop ignored in IDLE
    row(1,0,0, 8'h10,1,1, 4,1,1,0,0);
    row(0,0,0, 8'h10,1,1, 4,0,1,0,1);
    row(0,0,0, 8'h10,1,1, 4,1,1,0,0);
    row(0,0,0, 8'h10,1,1, 4,0,1,0,1);
    row(0,1,0, 8'h10,1,1, 4,0,0,1,0);
    row(0,0,0, 8'h10,1,1, 4,0,0,0,0);
    row(0,1,0, 8'h10,1,1, 4,0,0,0,0);

    // empty mask: done once, never busy
    row(1,0,0, 8'h00,3,0, 4,0,0,1,0);
    row(0,0,0, 8'h00,3,0, 4,0,0,0,0);

    // reset mid-scan: no done; reset beats start
    row(1,0,0, 8'h06,4,0, 1,1,1,0,0);
    row(0,0,0, 8'h06,4,0, 1,1,1,0,0);
    row(0,0,1, 8'h06,4,0, 0,0,0,0,0);
    row(0,0,0, 8'h06,4,0, 0,0,0,0,0);
    row(1,0,1, 8'hFF,4,0, 0,0,0,0,0);
    row(0,0,0, 8'hFF,4,0, 0,0,0,0,0);

    acc_mask = '0; prev_busy_exp = 1'b0; prev_en = 1'b0; prev_sel = '0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = q[i].st; stop = q[i].sp; rst = q[i].r;
      mask = q[i].m; dwell = q[i].dw; continuous = q[i].c;
      @(posedge clk);
      #1;
      if (q[i].r) acc_mask = '0;
      else if (q[i].st && !prev_busy_exp) acc_mask = q[i].m;
      chk("sel",    i, 8'(sel),    8'(q[i].es));
      chk("enable", i, 8'(enable), 8'(q[i].ee));
      chk("busy",   i, 8'(busy),   8'(q[i].eb));
      chk("done",   i, 8'(done),   8'(q[i].ed));
      chk("wrap",   i, 8'(wrap),   8'(q[i].ew));
      if (enable === 1'b1) chk("en_line_in_mask", i, 8'(acc_mask[sel]), 8'd1);
      if (enable === 1'b1 && prev_en) chk("sel_stable", i, 8'(sel), 8'(prev_sel));
      prev_busy_exp = q[i].eb;
      prev_en = (enable === 1'b1);
      prev_sel = sel;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell-time input and internal dwell counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one scan pass; sampled only in IDLE.
REQ-005 SHALL have port stop  input  1  abort scan; sampled in ACTIVE and BLANK.
REQ-006 SHALL have port mask  input  8  lines to visit (bit i = line i); latched on start acceptance.
REQ-007 SHALL have port dwell  input  DWELL_W  cycles per line; latched on start acceptance; value 0 treated as 1.
REQ-008 SHALL have port continuous  input  1  latched on start; 1 = wrap and rescan until stop.
REQ-009 SHALL have port sel  output  3  line index driving the downstream 3:8 decoder in[2:0].
REQ-010 SHALL have port enable  output  1  drives the downstream decoder enable.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a pass or abort.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when a continuous scan wraps to the lowest line.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, BLANK; enable is 1 only in ACTIVE.
REQ-015 SHALL, in IDLE with start=1 and latched-mask source mask!=0, move to ACTIVE with sel = index of the lowest set mask bit, visible the cycle after start.
REQ-016 SHALL, in IDLE with start=1 and mask==0, stay in IDLE, keep enable=0, and pulse done the following cycle.
REQ-017 SHALL hold enable=1 with a constant sel for exactly max(dwell,1) consecutive cycles per ACTIVE visit.
REQ-018 SHALL, at ACTIVE expiry with a higher set bit in the latched mask, enter BLANK for exactly 1 cycle (enable=0) with sel updated to the next higher set index on BLANK entry, then return to ACTIVE.
REQ-019 SHALL, at ACTIVE expiry on the highest set bit with continuous=1, enter BLANK with sel = lowest set index and pulse wrap in that BLANK cycle.
REQ-020 SHALL, at ACTIVE expiry on the highest set bit with continuous=0, return to IDLE with enable=0 and done=1 in the next cycle.
REQ-021 SHALL give stop priority over dwell expiry: stop=1 in ACTIVE or BLANK -> next cycle IDLE, enable=0, done=1, no wrap pulse.
REQ-022 SHALL ignore start while busy=1 and ignore stop while in IDLE.
REQ-023 SHALL never change sel while enable=1 (break-before-make: sel changes only on BLANK entry or IDLE->ACTIVE).
REQ-024 SHALL ignore changes on mask, dwell, continuous after acceptance until the next accepted start.
REQ-025 SHALL, with a single set mask bit and continuous=1, alternate ACTIVE(dwell) and BLANK(1) on that same sel, pulsing wrap each BLANK.
REQ-026 SHALL hold sel at its last value in IDLE.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, force IDLE, sel=0, enable=0, busy=0, done=0, wrap=0, and clear latched mask/dwell/continuous and the dwell counter, overriding start/stop in the same cycle.
REQ-028 SHALL, when reset is asserted mid-scan, not pulse done for the aborted pass.

Verification
REQ-029 SHALL cover: mask=8'b1010_0100, dwell=3, continuous=0, start pulse -> sel 2,5,7 each with enable=1 for 3 cycles, 1-cycle enable=0 gaps, done pulse 1 cycle after line 7, total 12 cycles start-to-done.
REQ-030 SHALL cover: mask=8'hFF, dwell=0 -> each line 0..7 enabled exactly 1 cycle, BLANK between lines, done after line 7.
REQ-031 SHALL cover: mask=8'b1000_0001, dwell=2, continuous=1 -> sel 0,7,0,7...; wrap pulses in each BLANK before sel 0; stop in ACTIVE -> enable=0 and done=1 next cycle.
REQ-032 SHALL cover: mask=0 with start -> enable never 1, busy stays 0, done pulses once.
REQ-033 SHALL cover: start asserted again and mask/dwell changed mid-scan -> scan order and dwell unchanged; rst mid-scan -> all outputs 0 next cycle, no done.
REQ-034 SHALL check every cycle: enable=1 implies mask bit sel was set at acceptance, and sel stable across each enable=1 run.
